// File: rtl/iob_plic_unit.sv
// Platform-level interrupt controller: per-source level/edge gateways, priority arbitration and claim/complete per target.
// Latency: src to irq is 4 cycles (2 sync flops, pending set, registered irq); a bus read returns data 1 cycle after acceptance.
// Backpressure: none; every request is accepted in the cycle it is presented (iob_ready_o tied high).
module iob_plic_unit #(
    parameter int ADDR_W            = 16,
    parameter int DATA_W            = 32,
    parameter int N_SOURCES         = 8,
    parameter int N_TARGETS         = 2,
    parameter int PRIORITIES        = 8,
    parameter int MAX_PENDING_COUNT = 8,
    parameter int HAS_THRESHOLD     = 1,
    parameter int HAS_CONFIG_REG    = 1
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    input  logic                  iob_avalid_i,
    input  logic [ADDR_W-1:0]     iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic                  iob_rvalid_o,
    output logic [DATA_W-1:0]     iob_rdata_o,
    output logic                  iob_ready_o,
    input  logic [N_SOURCES-1:0]  src,
    output logic [N_TARGETS-1:0]  irq
);
    localparam int PW  = $clog2(PRIORITIES);
    localparam int CW  = $clog2(MAX_PENDING_COUNT + 1);
    localparam int IDW = $clog2(N_SOURCES + 1);
    localparam int AW  = ADDR_W - 2;
    localparam logic [DATA_W-1:0] CFG_VAL = (HAS_CONFIG_REG != 0) ?
        DATA_W'({7'd0, (HAS_THRESHOLD != 0), 8'(PRIORITIES - 1), 8'(N_TARGETS), 8'(N_SOURCES)}) : '0;

    logic [N_SOURCES-1:0]                 src_s1_q, src_s1_d, src_s2_q, src_s2_d, src_s3_q, src_s3_d;
    logic [N_SOURCES-1:0]                 el_q, el_d, ip_q, ip_d, is_q, is_d;
    logic [N_TARGETS-1:0][N_SOURCES-1:0]  ie_q, ie_d;
    logic [N_SOURCES-1:0][PW-1:0]         prio_q, prio_d;
    logic [N_TARGETS-1:0][PW-1:0]         thresh_q, thresh_d;
    logic [N_SOURCES-1:0][CW-1:0]         cnt_q, cnt_d;
    logic [N_TARGETS-1:0]                 irq_q, irq_d;
    logic                                 rvalid_q, rvalid_d;
    logic [DATA_W-1:0]                    rdata_q, rdata_d;

    logic                                 rd_acc, wr_acc;
    logic [AW-1:0]                        waddr;
    logic [DATA_W-1:0]                    wmask, wdat_m, rd_val;
    logic [N_SOURCES-1:0]                 edge_inc, edge_dec;
    logic [N_TARGETS-1:0][IDW-1:0]        win_id;
    logic [N_TARGETS-1:0]                 cand_any;
    logic [PW-1:0]                        best_prio;
    logic [1:0]                           unused_addr_lsb;

    assign rd_acc          = iob_avalid_i & ~(|iob_wstrb_i);
    assign wr_acc          = iob_avalid_i & (|iob_wstrb_i);
    assign waddr           = iob_addr_i[ADDR_W-1:2];
    assign unused_addr_lsb = iob_addr_i[1:0];
    assign wdat_m          = iob_wdata_i & wmask;
    assign iob_ready_o     = 1'b1;
    assign iob_rvalid_o    = rvalid_q;
    assign iob_rdata_o     = rdata_q;
    assign irq             = irq_q;

    // Expand byte strobes into a bit mask and derive per-source edge-counter events
    always_comb begin
        wmask = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            wmask[8*b +: 8] = {8{iob_wstrb_i[b]}};
        end
        for (int i = 0; i < N_SOURCES; i++) begin
            edge_inc[i] = el_q[i] & src_s2_q[i] & ~src_s3_q[i];
            edge_dec[i] = el_q[i] & (cnt_q[i] != '0) & ~ip_q[i] & ~is_q[i];
        end
    end

    // Per-target winner: strict > while scanning upward keeps the lowest ID on priority ties
    always_comb begin
        win_id    = '0;
        cand_any  = '0;
        best_prio = '0;
        for (int t = 0; t < N_TARGETS; t++) begin
            best_prio = '0;
            for (int i = 0; i < N_SOURCES; i++) begin
                if (ip_q[i] && ie_q[t][i] && (prio_q[i] > thresh_q[t]) && (prio_q[i] > best_prio)) begin
                    best_prio   = prio_q[i];
                    win_id[t]   = IDW'(i + 1);
                    cand_any[t] = 1'b1;
                end
            end
        end
    end

    // Read data mux; unmapped word addresses fall through to zero
    always_comb begin
        rd_val = '0;
        if (waddr == AW'(0)) rd_val = CFG_VAL;
        if (waddr == AW'(1)) rd_val = DATA_W'(el_q);
        if (waddr == AW'(2)) rd_val = DATA_W'(ip_q);
        for (int t = 0; t < N_TARGETS; t++) begin
            if (waddr == AW'(16 + t))  rd_val = DATA_W'(ie_q[t]);
            if (waddr == AW'(128 + t)) rd_val = DATA_W'(thresh_q[t]);
            if (waddr == AW'(192 + t)) rd_val = DATA_W'(win_id[t]);
        end
        for (int i = 0; i < N_SOURCES; i++) begin
            if (waddr == AW'(64 + i)) rd_val = DATA_W'(prio_q[i]);
        end
    end

    // Next state: gateways first, then register writes, then claim/complete override the gateway result
    always_comb begin
        src_s1_d = src;
        src_s2_d = src_s1_q;
        src_s3_d = src_s2_q;
        el_d     = el_q;
        ie_d     = ie_q;
        prio_d   = prio_q;
        thresh_d = thresh_q;
        ip_d     = ip_q;
        is_d     = is_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < N_SOURCES; i++) begin
            if (el_q[i]) begin
                if (edge_dec[i]) ip_d[i] = 1'b1;
                if (edge_inc[i] && !edge_dec[i] && (cnt_q[i] != CW'(MAX_PENDING_COUNT)))
                    cnt_d[i] = cnt_q[i] + 1'b1;
                else if (edge_dec[i] && !edge_inc[i])
                    cnt_d[i] = cnt_q[i] - 1'b1;
            end else if (src_s2_q[i] && !ip_q[i] && !is_q[i]) begin
                ip_d[i] = 1'b1;
            end
        end
        if (wr_acc) begin
            if (waddr == AW'(1))
                el_d = N_SOURCES'((DATA_W'(el_q) & ~wmask) | wdat_m);
            for (int t = 0; t < N_TARGETS; t++) begin
                if (waddr == AW'(16 + t))
                    ie_d[t] = N_SOURCES'((DATA_W'(ie_q[t]) & ~wmask) | wdat_m);
                if ((HAS_THRESHOLD != 0) && (waddr == AW'(128 + t)))
                    thresh_d[t] = PW'((DATA_W'(thresh_q[t]) & ~wmask) | wdat_m);
                if (waddr == AW'(192 + t)) begin
                    for (int i = 0; i < N_SOURCES; i++) begin
                        if (wdat_m == DATA_W'(i + 1)) is_d[i] = 1'b0;
                    end
                end
            end
            for (int i = 0; i < N_SOURCES; i++) begin
                if (waddr == AW'(64 + i))
                    prio_d[i] = PW'((DATA_W'(prio_q[i]) & ~wmask) | wdat_m);
            end
        end
        if (rd_acc) begin
            for (int t = 0; t < N_TARGETS; t++) begin
                if ((waddr == AW'(192 + t)) && cand_any[t]) begin
                    for (int i = 0; i < N_SOURCES; i++) begin
                        if (win_id[t] == IDW'(i + 1)) begin
                            ip_d[i] = 1'b0;
                            is_d[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Registered outputs: irq follows candidate presence, read data held when no read completes
    always_comb begin
        irq_d    = cand_any;
        rvalid_d = rd_acc;
        rdata_d  = rd_acc ? rd_val : rdata_q;
    end

    // State registers; cke_i low freezes everything
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            src_s1_q <= '0;  src_s2_q <= '0;  src_s3_q <= '0;
            el_q     <= '0;  ip_q     <= '0;  is_q     <= '0;
            ie_q     <= '0;  prio_q   <= '0;  thresh_q <= '0;
            cnt_q    <= '0;  irq_q    <= '0;
            rvalid_q <= 1'b0; rdata_q <= '0;
        end else if (cke_i) begin
            src_s1_q <= src_s1_d; src_s2_q <= src_s2_d; src_s3_q <= src_s3_d;
            el_q     <= el_d;     ip_q     <= ip_d;     is_q     <= is_d;
            ie_q     <= ie_d;     prio_q   <= prio_d;   thresh_q <= thresh_d;
            cnt_q    <= cnt_d;    irq_q    <= irq_d;
            rvalid_q <= rvalid_d; rdata_q  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_iob_plic_unit.sv
// Bench for iob_plic_unit: bus reads queue their expected data, a monitor pops and compares on rvalid.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge or 1 unit after rising.
// All comparisons go through check_eq; waits on irq are bounded by a cycle budget.
module tb_iob_plic_unit;
    logic        clk_i = 1'b0;
    logic        cke_i = 1'b1;
    logic        arst_i = 1'b1;
    logic        iob_avalid_i = 1'b0;
    logic [15:0] iob_addr_i = '0;
    logic [31:0] iob_wdata_i = '0;
    logic [3:0]  iob_wstrb_i = '0;
    logic        iob_rvalid_o;
    logic [31:0] iob_rdata_o;
    logic        iob_ready_o;
    logic [7:0]  src = '0;
    logic [1:0]  irq;

    int          n_chk = 0;
    int          n_pass = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];
    logic        exp_rv;

    iob_plic_unit dut (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
        .iob_avalid_i(iob_avalid_i), .iob_addr_i(iob_addr_i),
        .iob_wdata_i(iob_wdata_i), .iob_wstrb_i(iob_wstrb_i),
        .iob_rvalid_o(iob_rvalid_o), .iob_rdata_o(iob_rdata_o),
        .iob_ready_o(iob_ready_o), .src(src), .irq(irq)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // A read accepted at a rising edge must show rvalid right after it; reset drops any read in flight
    always @(posedge clk_i or posedge arst_i) begin
        if (arst_i) exp_rv <= 1'b0;
        else        exp_rv <= iob_avalid_i && (iob_wstrb_i == 4'h0);
    end

    always @(negedge clk_i) begin
        if (iob_rvalid_o || exp_rv) begin
            check_eq("rvalid_timing", 32'(iob_rvalid_o), 32'(exp_rv));
            if (iob_rvalid_o) begin
                check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_eq(tag_q.pop_front(), iob_rdata_o, exp_q.pop_front());
            end
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        iob_avalid_i = 1'b1; iob_addr_i = a; iob_wdata_i = d; iob_wstrb_i = 4'hF;
        @(posedge clk_i); #1;
        iob_avalid_i = 1'b0; iob_wstrb_i = 4'h0;
    endtask

    task automatic bus_read(input string tag, input logic [15:0] a, input logic [31:0] e);
        iob_avalid_i = 1'b1; iob_addr_i = a; iob_wstrb_i = 4'h0;
        tag_q.push_back(tag); exp_q.push_back(e);
        @(posedge clk_i); #1;
        iob_avalid_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic wait_irq(input string tag, input int t, input logic v, input int budget);
        int n = 0;
        while (irq[t] !== v && n < budget) begin @(posedge clk_i); #1; n++; end
        check_eq(tag, 32'(irq[t]), 32'(v));
    endtask

    task automatic claim_complete(input string tag, input int t, input logic [31:0] e);
        bus_read(tag, 16'(16'h300 + 4 * t), e);
        if (e != 0) bus_write(16'(16'h300 + 4 * t), e);
        idle(1);
    endtask

    task automatic pulse(input int i);
        src[i] = 1'b1; idle(1);
        src[i] = 1'b0; idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        #3;
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_rvalid", 32'(iob_rvalid_o), 32'd0);
        check_eq("rst_rdata", iob_rdata_o, 32'd0);
        check_eq("ready", 32'(iob_ready_o), 32'd1);
        #19 arst_i = 1'b0;
        @(posedge clk_i); #1;

        bus_read("cfg", 16'h000, 32'h0107_0208);
        bus_read("ip_rst", 16'h008, 32'h0);
        bus_read("ie0_rst", 16'h040, 32'h0);
        bus_read("prio1_rst", 16'h104, 32'h0);
        bus_read("el_rst", 16'h004, 32'h0);
        bus_read("unmapped", 16'h0FC, 32'h0);

        // Level-triggered source 0 to target 0
        bus_write(16'h100, 32'd3);
        bus_write(16'h040, 32'h1);
        bus_write(16'h200, 32'd0);
        bus_write(16'h0FC, 32'hFFFF_FFFF);
        bus_read("prio0_rb", 16'h100, 32'd3);
        src[0] = 1'b1;
        wait_irq("lvl_irq0_up", 0, 1'b1, 4);
        check_eq("lvl_irq1_low", 32'(irq[1]), 32'd0);
        bus_read("lvl_claim", 16'h300, 32'd1);
        wait_irq("lvl_irq0_fall", 0, 1'b0, 3);
        bus_read("lvl_ip_inservice", 16'h008, 32'h0);
        bus_write(16'h300, 32'd1);
        wait_irq("lvl_repend", 0, 1'b1, 4);
        src[0] = 1'b0;
        idle(3);
        claim_complete("lvl_claim2", 0, 32'd1);
        idle(4);
        check_eq("lvl_stays_low", 32'(irq[0]), 32'd0);
        bus_read("lvl_ip_clear", 16'h008, 32'h0);
        bus_write(16'h040, 32'h0);

        // Priority ordering on target 1
        bus_write(16'h108, 32'd2);
        bus_write(16'h114, 32'd6);
        bus_write(16'h044, 32'h24);
        src[2] = 1'b1; src[5] = 1'b1;
        wait_irq("pri_irq1_up", 1, 1'b1, 6);
        check_eq("pri_irq0_low", 32'(irq[0]), 32'd0);
        bus_read("pri_claim_hi", 16'h304, 32'd6);
        bus_read("pri_claim_lo", 16'h304, 32'd3);
        bus_read("pri_claim_none", 16'h304, 32'd0);
        wait_irq("pri_irq1_fall", 1, 1'b0, 3);
        src[2] = 1'b0; src[5] = 1'b0;
        idle(3);
        bus_write(16'h304, 32'd9);
        bus_write(16'h304, 32'd6);
        bus_write(16'h304, 32'd3);
        // Equal priorities: lower ID first
        bus_write(16'h114, 32'd2);
        src[2] = 1'b1; src[5] = 1'b1;
        wait_irq("tie_irq1_up", 1, 1'b1, 6);
        bus_read("tie_claim_first", 16'h304, 32'd3);
        bus_read("tie_claim_second", 16'h304, 32'd6);
        src[2] = 1'b0; src[5] = 1'b0;
        idle(3);
        bus_write(16'h304, 32'd3);
        bus_write(16'h304, 32'd6);
        idle(2);
        bus_read("tie_ip_clear", 16'h008, 32'h0);
        bus_write(16'h044, 32'h0);

        // Threshold masking on target 0
        bus_write(16'h040, 32'h1);
        bus_write(16'h200, 32'd3);
        src[0] = 1'b1;
        idle(6);
        check_eq("thr_masked", 32'(irq[0]), 32'd0);
        bus_read("thr_claim_zero", 16'h300, 32'd0);
        bus_read("thr_ip_kept", 16'h008, 32'h1);
        bus_write(16'h200, 32'd2);
        bus_read("thr_rb", 16'h200, 32'd2);
        wait_irq("thr_irq_up", 0, 1'b1, 3);
        bus_read("thr_claim", 16'h300, 32'd1);
        src[0] = 1'b0;
        idle(3);
        bus_write(16'h300, 32'd1);

        // Edge-triggered source 1 with queued pulses
        bus_write(16'h040, 32'h2);
        bus_write(16'h104, 32'd4);
        bus_write(16'h004, 32'h2);
        bus_write(16'h200, 32'd0);
        for (int k = 0; k < 3; k++) pulse(1);
        idle(4);
        for (int k = 0; k < 3; k++) claim_complete("edge3_claim", 0, 32'd2);
        claim_complete("edge3_empty", 0, 32'd0);
        for (int k = 0; k < 10; k++) pulse(1);
        idle(4);
        for (int k = 0; k < 9; k++) claim_complete("edge10_claim", 0, 32'd2);
        claim_complete("edge10_saturated", 0, 32'd0);
        check_eq("edge_irq_low", 32'(irq[0]), 32'd0);

        // Asynchronous reset with irq high and a read in flight
        pulse(1);
        wait_irq("rst_pre_irq", 0, 1'b1, 8);
        iob_avalid_i = 1'b1; iob_addr_i = 16'h000; iob_wstrb_i = 4'h0;
        @(posedge clk_i); #2;
        arst_i = 1'b1; iob_avalid_i = 1'b0;
        #1;
        check_eq("rst_mid_irq", 32'(irq), 32'd0);
        check_eq("rst_mid_rvalid", 32'(iob_rvalid_o), 32'd0);
        @(posedge clk_i); #3 arst_i = 1'b0;
        @(posedge clk_i); #1;
        check_eq("rst_post_irq", 32'(irq), 32'd0);
        bus_read("rst_post_ip", 16'h008, 32'h0);
        bus_read("rst_post_el", 16'h004, 32'h0);
        bus_read("rst_post_ie0", 16'h040, 32'h0);
        bus_read("rst_post_prio1", 16'h104, 32'h0);
        bus_read("rst_post_thr0", 16'h200, 32'h0);
        bus_read("rst_post_claim", 16'h300, 32'h0);
        idle(2);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/iob_plic_unit.md
Name: iob_plic_unit

Overview:
- RISC-V style Platform-Level Interrupt Controller behind an IOb native slave port.
- Gathers N_SOURCES external interrupt sources through per-source level/edge gateways.
- Routes them to N_TARGETS hart interrupt lines using per-source priorities, per-target enables and per-target thresholds.
- Provides a claim/complete register per target.
- Sits between SoC peripherals and each core's machine external interrupt input.

Parameters:
ADDR_W  16  bus byte-address width
DATA_W  32  bus data width (only 32 supported)
N_SOURCES  8  interrupt sources, 1..31; source i (bit i of src) has ID i+1, ID 0 means "none"
N_TARGETS  2  interrupt targets, 1..16
PRIORITIES  8  priority levels, 2..256; priority field width PW = clog2(PRIORITIES)
MAX_PENDING_COUNT  8  max queued edges per edge-triggered source, >=1
HAS_THRESHOLD  1  1: threshold registers writable; 0: thresholds hardwired 0
HAS_CONFIG_REG  1  1: CONFIG register readable; 0: reads 0

Ports:
clk_i  in  1  clock, rising edge
cke_i  in  1  clock enable; low freezes all state
arst_i  in  1  asynchronous active-high reset
iob_avalid_i  in  1  request valid
iob_addr_i  in  ADDR_W  byte address (bits [1:0] ignored)
iob_wdata_i  in  DATA_W  write data
iob_wstrb_i  in  DATA_W/8  byte strobes; 0 = read
iob_rvalid_o  out  1  read data valid
iob_rdata_o  out  DATA_W  read data
iob_ready_o  out  1  request accepted
src  in  N_SOURCES  interrupt source inputs
irq  out  N_TARGETS  per-target interrupt request

Behaviour:
- One clock, clk_i. Reset arst_i is asynchronous and active-high.
- Reset values:
  - iob_rvalid_o=0, iob_rdata_o=0, irq=0.
  - EL, IE, priorities and thresholds = 0.
  - Pending, in-service and edge counters = 0.
  - Source sync registers = 0.
- Bus:
  - iob_ready_o constant 1.
  - Access accepted when iob_avalid_i=1.
  - Write when wstrb!=0; only enabled byte lanes update.
  - Read: iob_rdata_o registered, iob_rvalid_o=1 exactly one cycle after acceptance, else 0.
  - iob_rdata_o holds its last value when rvalid=0.
  - Unmapped addresses read 0, writes ignored.
- Register map (byte offsets):
  - 0x000 CONFIG (RO): [7:0] N_SOURCES, [15:8] N_TARGETS, [23:16] PRIORITIES-1, [24] HAS_THRESHOLD, [31:25]=0.
  - 0x004 EL (RW): bit i=1 makes source i edge-triggered; 0 = level.
  - 0x008 IP (RO): pending bits.
  - 0x040+4t IE[t] (RW): bit i enables source i for target t.
  - 0x100+4i PRIO[i] (RW, PW bits): priority of source i; 0 = never interrupts.
  - 0x200+4t THRESH[t] (RW, PW bits).
  - 0x300+4t ID[t]: read = claim, write = complete.
- Gateway:
  - src is synchronized through 2 flops.
  - Level source: pending set when synced src=1, not pending, not in-service.
  - Edge source: rising edge increments counter, saturating at MAX_PENDING_COUNT.
  - Edge source: when counter>0 and not pending and not in-service, set pending and decrement counter.
  - Increment and decrement in the same cycle leave the counter unchanged.
- Arbitration per target t:
  - Candidate sources: pending & IE[t] & PRIO > THRESH[t].
  - Winner: highest PRIO; ties go to the lowest ID.
  - irq[t] registered: 1 the cycle after a candidate exists, 0 the cycle after none remains.
- Claim (read ID[t]):
  - Returns the winner ID, or 0 if no candidate.
  - Winner's pending cleared and in-service set in the same cycle.
  - A claim that returns 0 has no side effect.
- Complete (write ID[t] with value k, 1..N_SOURCES): clears in-service of source k. Other values are ignored.
- Completing a not-in-service source has no effect.
- Level source still high after complete: re-pends next cycle.
- A claim/complete takes priority over a gateway pending-set in the same cycle.
- Changing EL, IE, PRIO or THRESH affects irq from the next cycle.
- Changing EL does not clear pending state.
- Reset mid-operation clears everything immediately; a read in flight is lost (no rvalid).

Test Plan:
- Read CONFIG (offset 0x000) after reset -> 0x01070208. Read IP, IE0, PRIO1 -> 0. irq=0. Every read gives rvalid exactly 1 cycle after avalid.
- Level: PRIO[0]=3, IE[0]=0x1, THRESH[0]=0, src[0]=1.
  - irq[0]=1 within 4 cycles; irq[1]=0.
  - Read ID[0] -> 1; irq[0] falls.
  - Write ID[0]=1 with src held high -> irq[0] reasserts.
  - Drop src, claim+complete -> irq stays 0.
- Priority: src[2] PRIO=2 and src[5] PRIO=6, both enabled for target 1, both high.
  - Claim ID[1] -> 6, then ID[1] -> 3, then ID[1] -> 0.
  - Equal priorities -> lower ID is claimed first.
- Threshold: PRIO[0]=3, THRESH[0]=3 -> irq[0]=0, claim returns 0. THRESH[0]=2 -> irq[0]=1.
- Edge: EL bit1=1, pulse src[1] three times.
  - Three claim/complete cycles each return 2; fourth claim returns 0.
  - 10 pulses -> only 8 claims beyond the one already pending (counter saturates).
- Reset: assert arst_i while irq[0]=1 -> irq, pending and registers read 0 immediately after release.
